// File: rtl/noc_flit_pkg.sv
// Shared flit header layout, packet length helper and depacketizer FSM states.
// Latency: none (package of constants, types and a constant function).
// Backpressure: not applicable.
package noc_flit_pkg;

  // Header bits are counted down from the flit MSB: FW-1 valid, FW-2 head, FW-3 tail.
  localparam int VALID_OFS = 1;
  localparam int HEAD_OFS  = 2;
  localparam int TAIL_OFS  = 3;
  localparam int HDR_BITS  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } fsm_state_t;

  // Flits needed for a payload of p bits: the head carries fw-3-v-a bits,
  // every further flit carries fw-3 bits.
  function automatic int num_flits(input int p, input int fw, input int a, input int v);
    int hc;
    int bw;
    int rest;
    hc   = fw - HDR_BITS - v - a;
    bw   = fw - HDR_BITS;
    rest = p - hc;
    if (rest <= 0) begin
      return 1;
    end
    return 1 + (rest + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry valid/ready output register for reassembled packets.
// Latency: load to out_vld is 1 cycle.
// Backpressure: load_rdy = !out_vld || out_rdy, so a drain and a reload can share a cycle.
module flit_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_vld,
  input  logic [W-1:0] load_dat,
  output logic         load_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  assign load_rdy = !out_vld || out_rdy;

  // Hold while stalled; otherwise take the new word or fall empty when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (load_rdy) begin
      out_vld <= load_vld;
      if (load_vld) begin
        out_dat <= load_dat;
      end
    end
  end

endmodule

// File: rtl/depacketizer_ta.sv
// Reassembles NoC flits into {vc, tag, data}; drops malformed/misrouted packets and counts them.
// Latency: tail flit accepted to valid_out high is 1 cycle.
// Backpressure: flit_ready_out follows the output register (!valid_out || ready_in).
module depacketizer_ta
  import noc_flit_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_DATA       = 12,
  parameter int WIDTH_TAG        = 8,
  parameter int FLIT_WIDTH       = 36,
  parameter int MY_ADDRESS       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_WIDTH-1:0]       flit_in,
  input  logic                        flit_valid_in,
  output logic                        flit_ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [WIDTH_TAG-1:0]        tag_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [7:0]                  err_count
);

  localparam int FW    = FLIT_WIDTH;
  localparam int A     = ADDRESS_WIDTH;
  localparam int V     = VC_ADDRESS_WIDTH;
  localparam int P     = WIDTH_DATA + WIDTH_TAG;
  localparam int BW    = FW - HDR_BITS;
  localparam int HC    = BW - V - A;
  localparam int NF    = num_flits(P, FW, A, V);
  localparam int ASM_W = HC + (NF - 1) * BW;
  localparam int CNT_W = $clog2(NF + 1);
  localparam int OUT_W = V + P;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NF - 1);

  if (HC < 1) begin : g_hc_check
    $error("depacketizer_ta: head flit has no payload bits (HC=%0d)", HC);
  end

  // Flit fields
  logic          f_valid;
  logic          f_head;
  logic          f_tail;
  logic [V-1:0]  f_vc;
  logic [A-1:0]  f_dst;
  logic [HC-1:0] f_hchunk;
  logic [BW-1:0] f_bchunk;

  assign f_valid  = flit_in[FW-VALID_OFS];
  assign f_head   = flit_in[FW-HEAD_OFS];
  assign f_tail   = flit_in[FW-TAIL_OFS];
  assign f_vc     = flit_in[BW-1 -: V];
  assign f_dst    = flit_in[BW-V-1 -: A];
  assign f_hchunk = flit_in[HC-1:0];
  assign f_bchunk = flit_in[BW-1:0];

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ASM_W-1:0] buf_q, buf_d;
  logic [V-1:0]     vc_q, vc_d;
  logic [7:0]       err_q, err_d;

  logic             accept;
  logic             take_head;
  logic [1:0]       err_add;
  logic             done;
  logic [P-1:0]     done_payload;
  logic [ASM_W-1:0] merged;
  logic [ASM_W-1:0] fresh;
  logic [8:0]       err_sum;
  logic             load_rdy;
  logic [OUT_W-1:0] out_dat;

  assign flit_ready_out = load_rdy;
  assign accept = flit_valid_in && flit_ready_out && f_valid;

  // Next-state decode: one flit per cycle against the current packet context.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    vc_d         = vc_q;
    err_add      = 2'd0;
    done         = 1'b0;
    done_payload = '0;
    take_head    = 1'b0;

    // Buffer with the current body chunk dropped into slot cnt.
    merged = buf_q;
    for (int i = 1; i < NF; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        merged[HC+(i-1)*BW +: BW] = f_bchunk;
      end
    end
    fresh = '0;
    fresh[HC-1:0] = f_hchunk;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (f_head) begin
            take_head = 1'b1;
          end else begin
            err_add = 2'd1;
          end
        end
        COLLECT: begin
          if (f_head) begin
            // New head aborts the partial packet and is then handled as a fresh start.
            err_add   = 2'd1;
            take_head = 1'b1;
          end else if (f_tail) begin
            if (cnt_q == LAST) begin
              done         = 1'b1;
              done_payload = merged[P-1:0];
            end else begin
              err_add = 2'd1;
            end
            state_d = IDLE;
          end else if (cnt_q >= LAST) begin
            err_add = 2'd1;
            state_d = DISCARD;
          end else begin
            buf_d = merged;
            cnt_d = cnt_q + 1'b1;
          end
        end
        DISCARD: begin
          if (f_head) begin
            take_head = 1'b1;
          end else if (f_tail) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_head) begin
        if (f_dst != A'(MY_ADDRESS)) begin
          err_add = err_add + 2'd1;
          // A misrouted single-flit packet is already over; nothing left to swallow.
          state_d = f_tail ? IDLE : DISCARD;
        end else begin
          vc_d  = f_vc;
          buf_d = fresh;
          cnt_d = CNT_W'(1);
          if (!f_tail) begin
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
            if (NF == 1) begin
              done         = 1'b1;
              done_payload = fresh[P-1:0];
            end else begin
              err_add = err_add + 2'd1;
            end
          end
        end
      end
    end
  end

  assign err_sum = {1'b0, err_q} + 9'(err_add);
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  // Packet context and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      vc_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      vc_q    <= vc_d;
      err_q   <= err_d;
    end
  end

  assign err_count = err_q;

  flit_out_reg #(.W(OUT_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load_vld (done),
    .load_dat ({vc_d, done_payload}),
    .load_rdy (load_rdy),
    .out_vld  (valid_out),
    .out_dat  (out_dat),
    .out_rdy  (ready_in)
  );

  assign data_out = out_dat[WIDTH_DATA-1:0];
  assign tag_out  = out_dat[P-1:WIDTH_DATA];
  assign vc_out   = out_dat[OUT_W-1:P];

endmodule

// File: tb/tb_depacketizer_ta.sv
module tb_depacketizer_ta;

  localparam int FW = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ready_in;
  bit   rdy_force;
  bit   rdy_val;

  // 3-flit instance: WIDTH_DATA=64 -> P=72, HC=28, body chunk 33
  logic [FW-1:0] b_flit;
  logic          b_fvld;
  logic          b_frdy;
  logic [63:0]   b_data;
  logic [7:0]    b_tag;
  logic          b_vc;
  logic          b_vout;
  logic [7:0]    b_err;

  // default instance: P=20, single-flit packets
  logic [FW-1:0] s_flit;
  logic          s_fvld;
  logic          s_frdy;
  logic [11:0]   s_data;
  logic [7:0]    s_tag;
  logic          s_vc;
  logic          s_vout;
  logic [7:0]    s_err;

  int tests = 0;
  int fails = 0;

  logic [72:0] b_q[$];
  logic [20:0] s_q[$];
  logic [72:0] b_exp;
  logic [20:0] s_exp;
  int b_err_m = 0;
  int s_err_m = 0;

  depacketizer_ta #(.WIDTH_DATA(64)) u_big (
    .clk(clk), .rst(rst), .flit_in(b_flit), .flit_valid_in(b_fvld), .flit_ready_out(b_frdy),
    .data_out(b_data), .tag_out(b_tag), .vc_out(b_vc), .valid_out(b_vout),
    .ready_in(ready_in), .err_count(b_err)
  );

  depacketizer_ta u_dflt (
    .clk(clk), .rst(rst), .flit_in(s_flit), .flit_valid_in(s_fvld), .flit_ready_out(s_frdy),
    .data_out(s_data), .tag_out(s_tag), .vc_out(s_vc), .valid_out(s_vout),
    .ready_in(ready_in), .err_count(s_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Downstream ready: random unless forced by a directed test.
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_in = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: every handshake on an output pops and compares one expected packet.
  always @(negedge clk) begin
    if (!rst && b_vout && ready_in) begin
      if (b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL big_unexpected: actual 0x%0h required no packet", {b_vc, b_tag, b_data});
      end else begin
        b_exp = b_q.pop_front();
        check("big_pkt", {b_vc, b_tag, b_data}, b_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_vout && ready_in) begin
      if (s_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL dflt_unexpected: actual 0x%0h required no packet", {s_vc, s_tag, s_data});
      end else begin
        s_exp = s_q.pop_front();
        check("dflt_pkt", {s_vc, s_tag, s_data}, s_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [FW-1:0] b_head(input logic tail, input logic vc,
                                           input logic [3:0] dst, input logic [27:0] c);
    return {1'b1, 1'b1, tail, vc, dst, c};
  endfunction

  function automatic logic [FW-1:0] b_body(input logic tail, input logic [32:0] c);
    return {1'b1, 1'b0, tail, c};
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic drive(input bit sm, input logic [FW-1:0] f, input logic v);
    if (sm) begin
      s_flit = f; s_fvld = v;
    end else begin
      b_flit = f; b_fvld = v;
    end
  endtask

  // Present one flit and hold it until accepted; optional idle/invalid-flit gap first.
  task automatic send(input bit sm, input logic [FW-1:0] f, input bit gap);
    int n;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        drive(sm, {1'b0, 3'($urandom()), 32'($urandom())}, 1'($urandom()));
        @(posedge clk);
        #1;
      end
    end
    drive(sm, f, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(sm ? s_frdy : b_frdy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: flit_ready_out stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    drive(sm, '0, 1'b0);
  endtask

  // Split P={tag,data} into chunks: 28 in the head, 33 in the body, 11 in the tail (rest junk).
  task automatic b_send_pkt(input logic [71:0] pl, input logic vc, input logic [3:0] dst, input bit gap);
    send(0, b_head(1'b0, vc, dst, pl[27:0]), gap);
    send(0, b_body(1'b0, pl[60:28]), gap);
    send(0, b_body(1'b1, {22'($urandom()), pl[71:61]}), gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((b_q.size() != 0 || s_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d/%0d packets still pending, required 0", b_q.size(), s_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic b_event(input int kind);
    logic [71:0] pl;
    logic        vc;
    pl = rnd72();
    vc = 1'($urandom());
    case (kind)
      0: begin  // good packet
        b_q.push_back({vc, pl});
        b_send_pkt(pl, vc, 4'd0, 1'b1);
      end
      1: begin  // misrouted packet: whole packet swallowed, one error
        b_send_pkt(pl, vc, 4'($urandom_range(1, 15)), 1'b1);
        b_err_m++;
      end
      2: begin  // stray non-head flit while idle
        send(0, b_body(1'($urandom()), 33'($urandom())), 1'b1);
        b_err_m++;
      end
      3: begin  // tail arriving after only the head
        send(0, b_head(1'b0, vc, 4'd0, pl[27:0]), 1'b1);
        send(0, b_body(1'b1, pl[60:28]), 1'b1);
        b_err_m++;
      end
      4: begin  // head abandoned by a new head; second packet must survive
        send(0, b_head(1'b0, vc, 4'd0, pl[27:0]), 1'b1);
        pl = rnd72();
        b_q.push_back({vc, pl});
        b_send_pkt(pl, vc, 4'd0, 1'b1);
        b_err_m++;
      end
      default: begin  // too many flits: one error, the rest swallowed up to the tail
        send(0, b_head(1'b0, vc, 4'd0, pl[27:0]), 1'b1);
        repeat (3) send(0, b_body(1'b0, 33'($urandom())), 1'b1);
        send(0, b_body(1'b1, 33'($urandom())), 1'b1);
        b_err_m++;
      end
    endcase
    check("big_err_evt", b_err, sat(b_err_m));
  endtask

  initial begin
    logic [71:0] pl;
    logic [19:0] sp;
    logic        vc;
    logic [72:0] snap;

    rst = 1'b1;
    b_flit = '0; b_fvld = 1'b0;
    s_flit = '0; s_fvld = 1'b0;
    rdy_force = 1'b1; rdy_val = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_big_valid", b_vout, 1'b0);
    check("rst_big_err", b_err, 8'd0);
    check("rst_big_dat", {b_vc, b_tag, b_data}, 73'd0);
    check("rst_big_rdy", b_frdy, 1'b1);
    check("rst_dflt_valid", s_vout, 1'b0);
    check("rst_dflt_err", s_err, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-flit packet on the default instance, one-cycle latency.
    s_q.push_back({1'b1, 8'hA5, 12'h123});
    send(1, {1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'h5A, 8'hA5, 12'h123}, 1'b0);
    @(negedge clk);
    check("dflt_lat_valid", s_vout, 1'b1);
    check("dflt_lat_tag", s_tag, 8'hA5);
    check("dflt_lat_data", s_data, 12'h123);
    check("dflt_lat_vc", s_vc, 1'b1);
    @(posedge clk);
    #1;

    // Misrouted single flit then random good single-flit packets under backpressure.
    send(1, {1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 28'($urandom())}, 1'b0);
    s_err_m++;
    check("dflt_err_dst", s_err, sat(s_err_m));
    rdy_force = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sp = 20'($urandom());
      vc = 1'($urandom());
      s_q.push_back({vc, sp});
      send(1, {1'b1, 1'b1, 1'b1, vc, 4'd0, 8'($urandom()), sp}, 1'b1);
    end
    drain();
    check("dflt_err_final", s_err, sat(s_err_m));

    // Three-flit packet back-to-back, one-cycle latency after the tail.
    rdy_force = 1'b1; rdy_val = 1'b1;
    @(posedge clk);
    #1;
    pl = rnd72();
    b_q.push_back({1'b1, pl});
    b_send_pkt(pl, 1'b1, 4'd0, 1'b0);
    @(negedge clk);
    check("big_lat_valid", b_vout, 1'b1);
    check("big_lat_dat", {b_vc, b_tag, b_data}, {1'b1, pl});
    drain();

    // Output stalled for 5 cycles while the next head waits.
    rdy_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pl = rnd72();
    b_q.push_back({1'b0, pl});
    b_send_pkt(pl, 1'b0, 4'd0, 1'b0);
    pl = rnd72();
    b_q.push_back({1'b1, pl});
    drive(0, b_head(1'b0, 1'b1, 4'd0, pl[27:0]), 1'b1);
    @(negedge clk);
    snap = b_q[0];
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", b_vout, 1'b1);
      check("bp_flit_rdy", b_frdy, 1'b0);
      check("bp_hold", {b_vc, b_tag, b_data}, snap);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    send(0, b_head(1'b0, 1'b1, 4'd0, pl[27:0]), 1'b0);
    send(0, b_body(1'b0, pl[60:28]), 1'b0);
    send(0, b_body(1'b1, {22'd0, pl[71:61]}), 1'b0);
    drain();
    check("bp_err", b_err, sat(b_err_m));

    // Randomized mix of good and malformed packets.
    rdy_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b_event(int'($urandom_range(0, 5)));
    end
    drain();

    // Reset in the middle of a packet.
    rdy_force = 1'b1; rdy_val = 1'b1;
    @(posedge clk);
    #1;
    pl = rnd72();
    send(0, b_head(1'b0, 1'b0, 4'd0, pl[27:0]), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_valid", b_vout, 1'b0);
    check("mid_rst_err", b_err, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_err_m = 0;
    s_err_m = 0;
    send(0, b_body(1'b0, pl[60:28]), 1'b0);
    b_err_m++;
    check("post_rst_err", b_err, sat(b_err_m));
    pl = rnd72();
    b_q.push_back({1'b1, pl});
    b_send_pkt(pl, 1'b1, 4'd0, 1'b0);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send(0, b_body(1'($urandom()), 33'($urandom())), 1'b0);
      b_err_m++;
      if (i == 200) check("err_mid", b_err, sat(b_err_m));
    end
    check("err_sat", b_err, sat(b_err_m));

    drain();
    check("big_q_empty", b_q.size(), 0);
    check("dflt_q_empty", s_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
